// File: rtl/demux8_rr_sched_if.sv
// rtl/demux8_rr_sched_if.sv - Upstream/downstream handshake bundle for demux8_rr_sched
interface demux8_rr_sched_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [7:0]       mask;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [7:0]       out_ready;
  logic [7:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       sel;
  logic             busy;
  logic [7:0]       sent_cnt;

  modport master (
    output en, mask, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, busy, sent_cnt
  );

  modport slave (
    input  en, mask, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, busy, sent_cnt
  );
endinterface

// File: rtl/demux8_rr_sched.sv
// rtl/demux8_rr_sched.sv - Round-robin scheduler holding one word and steering it to one of eight channels
module demux8_rr_sched #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  demux8_rr_sched_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [2:0]       sel_r;
  logic [WIDTH-1:0] data_r;
  logic [7:0]       cnt_r;

  logic       hold;
  logic       deliver;
  logic       ready;
  logic       accept;
  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] target;
  logic       found;

  // On a same-cycle delivery the search restarts past the channel just served.
  always_comb begin
    hold    = (state == HOLD);
    deliver = hold & bus.out_ready[sel_r];
    ready   = bus.en & (|bus.mask) & (~hold | deliver);
    accept  = bus.in_valid & ready;
    base    = deliver ? sel_r + 3'd1 : ptr;
    idx     = 3'd0;
    target  = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = base + i[2:0];
      if (!found && bus.mask[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      sel_r  <= 3'd0;
      data_r <= '0;
      cnt_r  <= 8'd0;
    end else begin
      if (deliver) begin
        ptr   <= sel_r + 3'd1;
        cnt_r <= cnt_r + 8'd1;
      end
      if (accept) begin
        state  <= HOLD;
        sel_r  <= target;
        data_r <= bus.in_data;
      end else if (deliver) begin
        state <= IDLE;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = hold ? (8'b1 << sel_r) : 8'b0;
  assign bus.out_data  = data_r;
  assign bus.sel       = sel_r;
  assign bus.busy      = hold;
  assign bus.sent_cnt  = cnt_r;
endmodule

// File: tb/tb_demux8_rr_sched.sv
// tb/tb_demux8_rr_sched.sv - Randomized and directed checks of demux8_rr_sched against a queue-free behavioural model
module tb_demux8_rr_sched;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  demux8_rr_sched_if #(.WIDTH(WIDTH)) bus ();
  demux8_rr_sched #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural model: a held word, its channel, the rotation origin and a delivery count.
  bit   m_held;
  int   m_sel, m_ptr, m_cnt;
  logic [WIDTH-1:0] m_data;
  bit   exp_rdy;

  logic             o_rdy, o_busy;
  logic [7:0]       o_valid, o_cnt;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_sel;

  function automatic int next_tgt(int start, logic [7:0] m);
    for (int k = 0; k < 8; k++)
      if (m[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_data = '0;
  endtask

  task automatic step(input bit e, input logic [7:0] m, input bit v,
                      input logic [WIDTH-1:0] d, input logic [7:0] r);
    bit deliver, acc;
    @(negedge clk);
    bus.en = e; bus.mask = m; bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
    #1;
    deliver = m_held && r[m_sel];
    exp_rdy = e && (m != 8'h00) && (!m_held || deliver);
    o_rdy = bus.in_ready;
    @(posedge clk);
    acc = v && exp_rdy;
    if (deliver) begin
      m_ptr = (m_sel + 1) % 8;
      m_cnt = (m_cnt + 1) % 256;
      m_held = 0;
    end
    if (acc) begin
      m_sel  = next_tgt(m_ptr, m);
      m_data = d;
      m_held = 1;
    end
    #1;
    o_valid = bus.out_valid; o_data = bus.out_data; o_sel = bus.sel;
    o_busy = bus.busy; o_cnt = bus.sent_cnt;
  endtask

  task automatic test_reset();
    bus.en = 0; bus.mask = 8'hFF; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 8'h00;
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.out_valid !== 8'h00) begin miscompares++; $display("FAIL reset_out_valid got %h want 00", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.sel !== 3'd0) begin miscompares++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    vectors++; if (bus.sent_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_sent_cnt got %0d want 0", bus.sent_cnt); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      step(1, 8'hFF, 1, 8'h11 + i[7:0], 8'hFF);
      vectors++; if (o_rdy !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, o_rdy); end
      vectors++; if (o_sel !== i[2:0]) begin miscompares++; $display("FAIL stream_sel[%0d] got %0d want %0d", i, o_sel, i); end
      vectors++; if (o_valid !== (8'h01 << i)) begin miscompares++; $display("FAIL stream_out_valid[%0d] got %h want %h", i, o_valid, 8'h01 << i); end
      vectors++; if (o_data !== 8'h11 + i[7:0]) begin miscompares++; $display("FAIL stream_out_data[%0d] got %h want %h", i, o_data, 8'h11 + i[7:0]); end
    end
    step(1, 8'hFF, 0, '0, 8'hFF);
    vectors++; if (o_cnt !== 8'd8) begin miscompares++; $display("FAIL stream_sent_cnt got %0d want 8", o_cnt); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL stream_idle got busy %b want 0", o_busy); end
  endtask

  task automatic test_mask_skip();
    int exp_t[6] = '{2, 5, 7, 2, 5, 7};
    for (int i = 0; i < 6; i++) begin
      step(1, 8'b1010_0100, 1, 8'hA0 + i[7:0], 8'hFF);
      vectors++; if (o_sel !== exp_t[i][2:0]) begin miscompares++; $display("FAIL mask_skip_sel[%0d] got %0d want %0d", i, o_sel, exp_t[i]); end
      vectors++; if (o_valid !== (8'h01 << exp_t[i])) begin miscompares++; $display("FAIL mask_skip_valid[%0d] got %h want %h", i, o_valid, 8'h01 << exp_t[i]); end
    end
    step(1, 8'hFF, 0, '0, 8'hFF);
  endtask

  task automatic test_stall();
    step(1, 8'h08, 1, 8'h3C, 8'hFF);
    vectors++; if (o_sel !== 3'd3) begin miscompares++; $display("FAIL stall_target got %0d want 3", o_sel); end
    for (int i = 0; i < 4; i++) begin
      step(1, 8'hFF, 1, 8'h99, 8'hF7);
      vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, o_rdy); end
      vectors++; if (o_valid !== 8'h08) begin miscompares++; $display("FAIL stall_out_valid[%0d] got %h want 08", i, o_valid); end
      vectors++; if (o_data !== 8'h3C) begin miscompares++; $display("FAIL stall_out_data[%0d] got %h want 3c", i, o_data); end
    end
    step(1, 8'hFF, 0, '0, 8'hFF);
    vectors++; if (o_busy !== 1'b0 || o_valid !== 8'h00) begin miscompares++; $display("FAIL stall_deliver got busy %b valid %h want 0 00", o_busy, o_valid); end
    vectors++; if (o_cnt !== m_cnt[7:0]) begin miscompares++; $display("FAIL stall_sent_cnt got %0d want %0d", o_cnt, m_cnt); end
  endtask

  task automatic test_en_drop();
    step(1, 8'h02, 1, 8'h5A, 8'h00);
    vectors++; if (o_sel !== 3'd1) begin miscompares++; $display("FAIL endrop_target got %0d want 1", o_sel); end
    step(0, 8'h80, 1, 8'h66, 8'h00);
    vectors++; if (o_valid !== 8'h02) begin miscompares++; $display("FAIL endrop_hold got %h want 02", o_valid); end
    step(0, 8'h80, 1, 8'h66, 8'hFF);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL endrop_delivered got busy %b want 0", o_busy); end
    step(0, 8'h80, 1, 8'h66, 8'hFF);
    vectors++; if (o_rdy !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL endrop_parked got ready %b busy %b want 0 0", o_rdy, o_busy); end
    step(1, 8'h80, 1, 8'h77, 8'h00);
    vectors++; if (o_sel !== 3'd7 || o_data !== 8'h77) begin miscompares++; $display("FAIL endrop_resume got sel %0d data %h want 7 77", o_sel, o_data); end
    step(1, 8'h80, 0, '0, 8'hFF);
  endtask

  task automatic test_async_reset();
    step(1, 8'hFF, 1, 8'hE1, 8'h00);
    step(1, 8'hFF, 0, '0, 8'h00);
    @(negedge clk);
    #2 rst = 1;
    #1;
    vectors++; if (bus.out_valid !== 8'h00) begin miscompares++; $display("FAIL arst_out_valid got %h want 00", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    vectors++; if (bus.sent_cnt !== 8'd0) begin miscompares++; $display("FAIL arst_sent_cnt got %0d want 0", bus.sent_cnt); end
    model_reset();
    @(negedge clk); rst = 0;
    step(1, 8'hFF, 1, 8'hB7, 8'hFF);
    vectors++; if (o_sel !== 3'd0 || o_valid !== 8'h01) begin miscompares++; $display("FAIL arst_first got sel %0d valid %h want 0 01", o_sel, o_valid); end
    step(1, 8'hFF, 0, '0, 8'hFF);
    vectors++; if (o_cnt !== 8'd1) begin miscompares++; $display("FAIL arst_restart_cnt got %0d want 1", o_cnt); end
  endtask

  task automatic test_mask_zero();
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h00, 1, 8'hC3, 8'hFF);
      vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL mask0_in_ready[%0d] got %b want 0", i, o_rdy); end
      vectors++; if (o_valid !== 8'h00) begin miscompares++; $display("FAIL mask0_out_valid[%0d] got %h want 00", i, o_valid); end
    end
  endtask

  task automatic test_random();
    logic [7:0] m, r;
    logic [7:0] exp_v;
    for (int n = 0; n < 400; n++) begin
      m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      r = 8'($urandom) | (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00);
      step($urandom_range(0, 7) != 0, m, $urandom_range(0, 3) != 0, WIDTH'($urandom), r);
      exp_v = m_held ? (8'h01 << m_sel) : 8'h00;
      vectors++; if (o_rdy !== exp_rdy) begin miscompares++; $display("FAIL rand_in_ready[%0d] got %b want %b", n, o_rdy, exp_rdy); end
      vectors++; if (o_valid !== exp_v) begin miscompares++; $display("FAIL rand_out_valid[%0d] got %h want %h", n, o_valid, exp_v); end
      vectors++; if (o_data !== m_data) begin miscompares++; $display("FAIL rand_out_data[%0d] got %h want %h", n, o_data, m_data); end
      vectors++; if (o_sel !== m_sel[2:0]) begin miscompares++; $display("FAIL rand_sel[%0d] got %0d want %0d", n, o_sel, m_sel); end
      vectors++; if (o_busy !== m_held) begin miscompares++; $display("FAIL rand_busy[%0d] got %b want %b", n, o_busy, m_held); end
      vectors++; if (o_cnt !== m_cnt[7:0]) begin miscompares++; $display("FAIL rand_sent_cnt[%0d] got %0d want %0d", n, o_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mask_skip();
    test_stall();
    test_en_drop();
    test_async_reset();
    test_mask_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t want completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
